imem_responder: RTL

//   Instruction-memory responder: the memory side of the cpu fetch interface.
//   The cpu drives instr_addr every cycle; this block returns the addressed word on instr after READ_LATENCY cycles.
//   A program-load write port fills the memory before fetch is enabled.

---
 rtl/imem_responder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
`default_nettype none
//============================================================================
// Module      : imem_responder
// Description : Instruction-memory responder for the cpu fetch interface.
//               A boot loader fills the word array through the prog_* port
//               while the block is in LOAD. After prog_done the block enters
//               RUN and returns one fetch result per cycle, READ_LATENCY
//               cycles after instr_addr is sampled.
//
// Ports       : clk             clock, all logic on posedge
//               rst_n           synchronous active-low reset
//               instr_addr      byte fetch address from the cpu
//               instr           fetched instruction word
//               instr_valid     instr holds a real fetch result this cycle
//               addr_misaligned the fetch behind instr had instr_addr[1:0]!=0
//               prog_we         program-load write strobe (LOAD only)
//               prog_addr       word index for a load write
//               prog_data       load write data
//               prog_done       end of load, enter RUN
//               loading         1 while in LOAD
//               fetch_count     number of instr_valid cycles since reset
//
// Revision    : 1.0  initial release
//============================================================================
module imem_responder #(
    parameter int          DEPTH        = 256,
    parameter int          ADDR_W       = 8,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr_addr,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              addr_misaligned,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    input  logic              prog_done,
    output logic              loading,
    output logic [31:0]       fetch_count
);

    //------------------------------------------------------------------------
    // Elaboration guard: the pipeline depth is only defined for 1..4.
    //------------------------------------------------------------------------
    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_latency_check
            $error("imem_responder: READ_LATENCY must be within 1..4");
        end
    endgenerate

    // Word count as a 32-bit value so the range check compares equal widths.
    localparam logic [31:0] c_DEPTH_WORDS = 32'(DEPTH);

    //------------------------------------------------------------------------
    // Control FSM: LOAD until prog_done, then RUN until the next reset.
    //------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD: begin
                if (prog_done) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // Only reset leaves RUN.
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_LOAD;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Instruction storage. Deliberately not reset so a loaded program
    // survives a reset and can be restarted with prog_done alone.
    // Writes are only accepted in LOAD, so RUN reads never race a write.
    //------------------------------------------------------------------------
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if ((r_state == ST_LOAD) && prog_we) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    //------------------------------------------------------------------------
    // Fetch result selection at sample time.
    // Misalignment wins over out-of-range; out-of-range addresses never wrap
    // onto the array, they return the NOP word instead.
    //------------------------------------------------------------------------
    logic        w_sample_valid;
    logic        w_addr_misaligned;
    logic        w_addr_out_of_range;
    logic [31:0] w_sample_data;
    logic        w_sample_mis;

    always_comb begin
        w_sample_valid      = (r_state == ST_RUN);
        w_addr_misaligned   = (instr_addr[1:0] != 2'b00);
        w_addr_out_of_range = ({2'b00, instr_addr[31:2]} >= c_DEPTH_WORDS);
        w_sample_data       = NOP_WORD;
        w_sample_mis        = 1'b0;
        if (w_sample_valid) begin
            if (w_addr_misaligned) begin
                w_sample_mis = 1'b1;
            end else if (!w_addr_out_of_range) begin
                w_sample_data = r_mem[instr_addr[ADDR_W+1:2]];
            end
        end
    end

    //------------------------------------------------------------------------
    // Latency pipeline. Stage 0 captures the sample; the last stage drives
    // the outputs. Invalid stages always carry NOP/aligned so the outputs
    // read correctly in LOAD without extra muxing at the tail.
    //------------------------------------------------------------------------
    logic        r_pipe_valid [READ_LATENCY];
    logic [31:0] r_pipe_data  [READ_LATENCY];
    logic        r_pipe_mis   [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_valid[i] <= 1'b0;
                r_pipe_data[i]  <= NOP_WORD;
                r_pipe_mis[i]   <= 1'b0;
            end
        end else begin
            r_pipe_valid[0] <= w_sample_valid;
            r_pipe_data[0]  <= w_sample_data;
            r_pipe_mis[0]   <= w_sample_mis;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_data[i]  <= r_pipe_data[i-1];
                r_pipe_mis[i]   <= r_pipe_mis[i-1];
            end
        end
    end

    //------------------------------------------------------------------------
    // Valid bit about to enter the last stage. fetch_count advances on the
    // same edge that raises instr_valid, so it already includes the result
    // currently on instr.
    //------------------------------------------------------------------------
    logic w_last_stage_in_valid;

    generate
        if (READ_LATENCY == 1) begin : g_last_from_sample
            assign w_last_stage_in_valid = w_sample_valid;
        end else begin : g_last_from_chain
            assign w_last_stage_in_valid = r_pipe_valid[READ_LATENCY-2];
        end
    endgenerate

    logic [31:0] r_fetch_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_count <= 32'd0;
        end else if (w_last_stage_in_valid) begin
            // Natural 32-bit wrap from 0xFFFFFFFF to 0.
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    //------------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------------
    assign instr           = r_pipe_data[READ_LATENCY-1];
    assign instr_valid     = r_pipe_valid[READ_LATENCY-1];
    assign addr_misaligned = r_pipe_mis[READ_LATENCY-1];
    assign loading         = (r_state == ST_LOAD);
    assign fetch_count     = r_fetch_count;

endmodule
`default_nettype wire
